// File: rtl/io_rx_controller.sv
// Byte-stream to image SRAM loader: accepts pixels over valid/ready and writes
// them row-major with a one-cycle registered SRAM write.

package img_sram_pkg;
  typedef struct packed {
    logic       sense_en;
    logic       write_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
  } img_sram_ctrl_t;
endpackage

module io_rx_controller
  import img_sram_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [7:0]     nrows,
  input  logic [7:0]     ncols,
  input  logic [7:0]     din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic           busy,
  output logic           done,
  output logic           err_stray,
  output img_sram_ctrl_t sram_ctrl
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] row_idx_reg, row_idx_next;
  logic [7:0] col_idx_reg, col_idx_next;
  logic [7:0] nrows_l_reg, nrows_l_next;
  logic [7:0] ncols_l_reg, ncols_l_next;
  logic       err_stray_reg, err_stray_next;
  logic       wr_en_reg, wr_en_next;
  logic [7:0] wr_row_reg, wr_row_next;
  logic [7:0] wr_col_reg, wr_col_next;
  logic [7:0] wr_din_reg, wr_din_next;

  // Widened increments so a 255 index compares correctly instead of wrapping.
  logic [8:0] col_inc;
  logic [8:0] row_inc;
  logic       last_col;
  logic       last_pix;

  assign col_inc  = {1'b0, col_idx_reg} + 9'd1;
  assign row_inc  = {1'b0, row_idx_reg} + 9'd1;
  assign last_col = (col_inc > {1'b0, ncols_l_reg});
  assign last_pix = last_col && (row_inc > {1'b0, nrows_l_reg});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      row_idx_reg   <= '0;
      col_idx_reg   <= '0;
      nrows_l_reg   <= '0;
      ncols_l_reg   <= '0;
      err_stray_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_row_reg    <= '0;
      wr_col_reg    <= '0;
      wr_din_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      nrows_l_reg   <= nrows_l_next;
      ncols_l_reg   <= ncols_l_next;
      err_stray_reg <= err_stray_next;
      wr_en_reg     <= wr_en_next;
      wr_row_reg    <= wr_row_next;
      wr_col_reg    <= wr_col_next;
      wr_din_reg    <= wr_din_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    row_idx_next   = row_idx_reg;
    col_idx_next   = col_idx_reg;
    nrows_l_next   = nrows_l_reg;
    ncols_l_next   = ncols_l_reg;
    err_stray_next = err_stray_reg;
    wr_en_next     = 1'b0;
    wr_row_next    = wr_row_reg;
    wr_col_next    = wr_col_reg;
    wr_din_next    = wr_din_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next     = WRITE;
          nrows_l_next   = nrows;
          ncols_l_next   = ncols;
          row_idx_next   = '0;
          col_idx_next   = '0;
          err_stray_next = 1'b0;
        end
      end

      WRITE: begin
        if (abort) begin
          // A beat handshaken alongside abort is dropped, never written.
          state_next   = IDLE;
          row_idx_next = '0;
          col_idx_next = '0;
        end else if (din_valid) begin
          wr_en_next  = 1'b1;
          wr_row_next = row_idx_reg;
          wr_col_next = col_idx_reg;
          wr_din_next = din;
          if (last_pix) begin
            state_next = DONE;
          end else if (last_col) begin
            col_idx_next = '0;
            row_idx_next = row_inc[7:0];
          end else begin
            col_idx_next = col_inc[7:0];
          end
        end
      end

      DONE: begin
        state_next   = IDLE;
        row_idx_next = '0;
        col_idx_next = '0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (din_valid && (state_reg != WRITE)) begin
      err_stray_next = 1'b1;
    end
  end

  assign din_ready = (state_reg == WRITE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err_stray = err_stray_reg;

  assign sram_ctrl.sense_en = 1'b0;
  assign sram_ctrl.write_en = wr_en_reg;
  assign sram_ctrl.row      = wr_row_reg;
  assign sram_ctrl.col      = wr_col_reg;
  assign sram_ctrl.din      = wr_din_reg;

endmodule

// File: tb/tb_io_rx_controller.sv
// Directed bench for io_rx_controller: a per-cycle vector table plus
// hand-written sequences for bubbles, 1x1, 256x256, abort, reset and strays.

module tb_io_rx_controller;
  import img_sram_pkg::*;

  logic           clk;
  logic           rst;
  logic           start;
  logic           abort;
  logic [7:0]     nrows;
  logic [7:0]     ncols;
  logic [7:0]     din;
  logic           din_valid;
  logic           din_ready;
  logic           busy;
  logic           done;
  logic           err_stray;
  img_sram_ctrl_t sram_ctrl;

  int errors = 0;
  int checks = 0;

  logic [23:0] wq[$];
  int          done_cnt = 0;

  io_rx_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .nrows     (nrows),
    .ncols     (ncols),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .err_stray (err_stray),
    .sram_ctrl (sram_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every SRAM write and done pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (sram_ctrl.write_en) wq.push_back({sram_ctrl.row, sram_ctrl.col, sram_ctrl.din});
    if (done) done_cnt++;
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] nr;
    logic [7:0] nc;
    logic       dv;
    logic [7:0] din;
    logic       chk_addr;
    logic       e_we;
    logic [7:0] e_row;
    logic [7:0] e_col;
    logic [7:0] e_din;
    logic       e_busy;
    logic       e_done;
    logic       e_rdy;
    logic       e_err;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 8'h00;
  endtask

  task automatic check_queue(input string name, input int n, input int row0,
                             input int ncol, input logic [7:0] din0);
    int bad = 0;
    chk({name, "_count"}, wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++) begin
      logic [23:0] e;
      e = {8'(row0 + k / ncol), 8'(k % ncol), 8'(din0 + k)};
      if (wq[k] !== e) bad++;
    end
    chk({name, "_entries"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1; nrows = 8'd0; ncols = 8'd0;
    idle_inputs();

    // rst start nr nc dv din chk_addr | we row col din busy done rdy err
    vecs[0]  = '{1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 2, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0};
    vecs[2]  = '{0, 0, 1, 2, 1, 8'h10, 1, 1, 0, 0, 8'h10, 1, 0, 1, 0};
    vecs[3]  = '{0, 0, 1, 2, 1, 8'h11, 1, 1, 0, 1, 8'h11, 1, 0, 1, 0};
    vecs[4]  = '{0, 0, 1, 2, 1, 8'h12, 1, 1, 0, 2, 8'h12, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 1, 2, 1, 8'h13, 1, 1, 1, 0, 8'h13, 1, 0, 1, 0};
    vecs[6]  = '{0, 0, 1, 2, 1, 8'h14, 1, 1, 1, 1, 8'h14, 1, 0, 1, 0};
    vecs[7]  = '{0, 0, 1, 2, 1, 8'h15, 1, 1, 1, 2, 8'h15, 1, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 2, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 2, 1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1};
    vecs[10] = '{0, 1, 1, 2, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; nrows = vecs[i].nr; ncols = vecs[i].nc;
      din_valid = vecs[i].dv; din = vecs[i].din; abort = 1'b0;
      step();
      $display("vec %0d: we=%0d row=%0d col=%0d din=%02h busy=%0d done=%0d rdy=%0d err=%0d",
               i, sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din,
               busy, done, din_ready, err_stray);
      chk($sformatf("v%0d_we", i), sram_ctrl.write_en, vecs[i].e_we);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_rdy", i), din_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d_err", i), err_stray, vecs[i].e_err);
      chk($sformatf("v%0d_sense", i), sram_ctrl.sense_en, 1'b0);
      if (vecs[i].chk_addr) begin
        chk($sformatf("v%0d_row", i), sram_ctrl.row, vecs[i].e_row);
        chk($sformatf("v%0d_col", i), sram_ctrl.col, vecs[i].e_col);
        chk($sformatf("v%0d_din", i), sram_ctrl.din, vecs[i].e_din);
      end
    end

    // Bubbles after the 3rd beat; a stray start with new dims mid-frame is ignored.
    begin
      logic pat[9] = '{1, 1, 1, 0, 0, 1, 1, 1, 0};
      int beat = 0;
      wq.delete(); done_cnt = 0;
      for (int i = 0; i < 9; i++) begin
        din_valid = pat[i];
        din = 8'(8'h20 + beat);
        start = (i == 3);
        nrows = (i == 3) ? 8'd0 : 8'd1;
        ncols = (i == 3) ? 8'd0 : 8'd2;
        step();
        if (pat[i]) beat++;
        $display("bubble %0d: dv=%0d we=%0d row=%0d col=%0d din=%02h done=%0d busy=%0d",
                 i, pat[i], sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col,
                 sram_ctrl.din, done, busy);
        chk($sformatf("bub%0d_we", i), sram_ctrl.write_en, pat[i]);
        chk($sformatf("bub%0d_done", i), done, (i == 7));
      end
      chk("bub_busy_after", busy, 1'b0);
      idle_inputs();
      step();
      check_queue("bub_writes", 6, 0, 3, 8'h20);
      chk("bub_done_cnt", done_cnt, 1);
    end

    // 1x1 frame: the only beat goes straight to DONE.
    wq.delete(); done_cnt = 0;
    nrows = 8'd0; ncols = 8'd0; start = 1'b1;
    step();
    start = 1'b0; din_valid = 1'b1; din = 8'hAB;
    step();
    $display("1x1: we=%0d row=%0d col=%0d din=%02h done=%0d rdy=%0d",
             sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din, done, din_ready);
    chk("one_we", sram_ctrl.write_en, 1'b1);
    chk("one_addr", {sram_ctrl.row, sram_ctrl.col, sram_ctrl.din}, 24'h0000AB);
    chk("one_done", done, 1'b1);
    chk("one_rdy", din_ready, 1'b0);
    din_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("one_busy_after", busy, 1'b0);
    chk("one_done_cnt", done_cnt, 1);
    chk("one_err", err_stray, 1'b0);

    // 256x256 continuous frame.
    nrows = 8'd255; ncols = 8'd255; start = 1'b1;
    step();
    start = 1'b0; wq.delete(); done_cnt = 0;
    for (int i = 0; i < 65536; i++) begin
      din_valid = 1'b1; din = 8'(i);
      step();
    end
    idle_inputs();
    step();
    step();
    $display("big: writes=%0d done_cnt=%0d", wq.size(), done_cnt);
    check_queue("big", 65536, 0, 256, 8'h00);
    chk("big_done_cnt", done_cnt, 1);
    chk("big_busy_after", busy, 1'b0);

    // 4x4 frame aborted on the 5th beat.
    nrows = 8'd3; ncols = 8'd3; start = 1'b1;
    step();
    start = 1'b0; wq.delete(); done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      din_valid = 1'b1; din = 8'(8'h40 + k); abort = (k == 4);
      step();
    end
    $display("abort: we=%0d busy=%0d done=%0d", sram_ctrl.write_en, busy, done);
    chk("abort_we", sram_ctrl.write_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    idle_inputs();
    step();
    check_queue("abort_writes", 4, 0, 4, 8'h40);
    chk("abort_done_cnt", done_cnt, 0);
    start = 1'b1;
    step();
    start = 1'b0; din_valid = 1'b1; din = 8'h77;
    step();
    $display("restart: we=%0d row=%0d col=%0d din=%02h",
             sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din);
    chk("restart_write", {sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din},
        {1'b1, 24'h000077});
    din_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;

    // abort together with start in IDLE keeps the block idle.
    start = 1'b1; abort = 1'b1;
    step();
    idle_inputs();
    $display("abort+start: busy=%0d", busy);
    chk("abort_start_idle", busy, 1'b0);

    // Same 4x4 frame with rst on the 5th beat.
    start = 1'b1;
    step();
    start = 1'b0; wq.delete(); done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      din_valid = 1'b1; din = 8'(8'h60 + k); rst = (k == 4);
      step();
    end
    rst = 1'b0;
    $display("rst: ctrl=%07h busy=%0d done=%0d rdy=%0d err=%0d",
             sram_ctrl, busy, done, din_ready, err_stray);
    chk("rst_ctrl", sram_ctrl, 26'd0);
    chk("rst_flags", {busy, done, din_ready, err_stray}, 4'b0000);
    idle_inputs();
    step();
    check_queue("rst_writes", 4, 0, 4, 8'h60);
    nrows = 8'd3; ncols = 8'd3; start = 1'b1;
    step();
    start = 1'b0; din_valid = 1'b1; din = 8'h88;
    step();
    din_valid = 1'b0;
    $display("rst restart: we=%0d row=%0d col=%0d din=%02h",
             sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din);
    chk("rst_restart_write", {sram_ctrl.write_en, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din},
        {1'b1, 24'h000088});
    step();
    chk("rst_restart_no_err", err_stray, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
